video_cache_writer: RTL

VIDEO_CACHE_WRITER -- requirements
Module: video_cache_writer

---
 rtl/video_cache_writer_pkg.sv | 14 +
 rtl/video_cache_writer_pixel_unpack.sv | 28 ++
 rtl/video_cache_writer.sv | 96 +++++++++
 3 files changed

// File: rtl/video_cache_writer_pkg.sv
// video_cache_writer_pkg: shared constants, phase type and phase sequencing for the video cache writer.
package video_cache_writer_pkg;

    localparam int COLOR_LEN            = 12;
    localparam int FRAME_PIXELS_DEFAULT = 1024;
    localparam int PACKET_BUFFER_SIZE   = 1024;

    typedef enum logic [1:0] {IDLE, PH0, PH1, PH2} phase_t;

    function automatic phase_t next_phase(input phase_t p);
        return (p == PH0) ? PH1 : (p == PH1) ? PH2 : PH0;
    endfunction

endpackage

// File: rtl/video_cache_writer_pixel_unpack.sv
// pixel_unpack: turns a 3-byte group into two 12-bit pixels, keeping the previous byte of the group.
module pixel_unpack
    import video_cache_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 take,
    input  logic [1:0]           role,
    input  logic [7:0]           data,
    output logic                 pix_vld,
    output logic [COLOR_LEN-1:0] pix
);

    logic [7:0] part_q, part_d;

    // role is the phase this byte plays: PH0 opens a group, PH1/PH2 each complete one pixel
    always_comb begin
        pix_vld = take & ((role == PH1) | (role == PH2));
        pix     = (role == PH1) ? {part_q, data[7:4]} : {part_q[3:0], data};
        part_d  = take ? data : part_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) part_q <= '0;
        else     part_q <= part_d;
    end

endmodule

// File: rtl/video_cache_writer.sv
// video_cache_writer: writes a packed 12-bit pixel stream into the video cache RAM, one frame per packet.
module video_cache_writer
    import video_cache_writer_pkg::*;
#(
    parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_start,
    input  logic                        in_end,
    input  logic [7:0]                  in_data,
    output logic                        ram_write_req,
    output logic [$clog2(RAM_SIZE)-1:0] ram_write_addr,
    output logic [COLOR_LEN-1:0]        ram_write_val,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int AW = $clog2(RAM_SIZE);

    phase_t               state_q, state_d, role;
    logic [AW-1:0]        cnt_q, cnt_d, addr_q, addr_d;
    logic [COLOR_LEN-1:0] val_q, val_d, pix;
    logic                 req_q, req_d, done_q, done_d, err_q, err_d;
    logic                 start, take, last, pix_vld;

    pixel_unpack u_unpack (
        .clk     (clk),
        .rst     (rst),
        .take    (take),
        .role    (role),
        .data    (in_data),
        .pix_vld (pix_vld),
        .pix     (pix)
    );

    // every response is registered, so it appears one cycle after the accepted byte
    always_comb begin
        start   = in_valid & in_start;
        take    = in_valid & (in_start | (state_q != IDLE));
        role    = start ? PH0 : state_q;
        last    = pix_vld & (cnt_q == AW'(FRAME_PIXELS - 1));
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        val_d   = val_q;
        req_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (take && start) begin
            err_d   = (state_q != IDLE) | in_end;
            cnt_d   = '0;
            state_d = in_end ? IDLE : PH1;
        end else if (take) begin
            done_d  = last;
            err_d   = in_end & ~last;
            state_d = (last || in_end) ? IDLE : next_phase(state_q);
            if (pix_vld) begin
                req_d  = 1'b1;
                addr_d = cnt_q;
                val_d  = pix;
                cnt_d  = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            val_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_write_req  = req_q;
    assign ram_write_addr = addr_q;
    assign ram_write_val  = val_q;
    assign frame_done     = done_q;
    assign frame_err      = err_q;

endmodule
